obstacle_gen: RTL and testbench

Column-stream source for the scrolling 16x16 playfield. The block generates pipe obstacles one column at a time: a solid 16-row wall with a pseudo-random gap of `GAP_H` rows, `PIPE_W` columns wide, followed by `SPACING` empty columns. Each column is presented on `column` together with a one-cycle `shift_en` pulse at a programmable scroll rate. It sits upstream of the playfield shift register: `column` feeds its obstacle input and `shift_en` feeds its enable.

---
 rtl/obstacle_gen.sv | 86 ++++++++
 tb/tb_obstacle_gen.sv | 110 +++++++++++
 2 files changed

// File: rtl/obstacle_gen.sv
// obstacle_gen: scrolling pipe-obstacle column generator with LFSR-placed gaps
module obstacle_gen #(
  parameter int TICK_DIV = 12_500_000,
  parameter int GAP_H    = 4,
  parameter int PIPE_W   = 2,
  parameter int SPACING  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        hold,
  output logic [15:0] column,
  output logic        shift_en,
  output logic [7:0]  pipe_count
);
  localparam int TW   = $clog2(TICK_DIV);
  localparam int CMAX = PIPE_W > SPACING ? PIPE_W : SPACING;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [4:0]  MAXLO    = 5'(16 - GAP_H);
  localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_H) - 32'd1);
  typedef enum logic [1:0] {IDLE, PIPE, SPACE} state_t;
  state_t          state, state_n;
  logic [7:0]      lfsr, lfsr_n, count_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [CW-1:0]   col_cnt, col_n;
  logic [15:0]     column_n, pipe_col;
  logic [4:0]      raw, gap_lo;
  logic            start;
  assign raw      = {1'b0, lfsr[3:0]};
  assign gap_lo   = raw > MAXLO ? raw - MAXLO - 5'd1 : raw;
  assign pipe_col = ~(GAP_MASK << gap_lo);
  assign shift_en = (state != IDLE) && !hold && (tick_cnt == TW'(TICK_DIV - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= 8'hA5;
      tick_cnt   <= '0;
      col_cnt    <= '0;
      column     <= '0;
      pipe_count <= '0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      tick_cnt   <= tick_n;
      col_cnt    <= col_n;
      column     <= column_n;
      pipe_count <= count_n;
    end
  end
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    tick_n   = tick_cnt;
    col_n    = col_cnt;
    column_n = column;
    count_n  = pipe_count;
    start    = 1'b0;
    if (!run) begin
      state_n  = IDLE;
      tick_n   = '0;
      col_n    = '0;
      column_n = '0;
    end else if (state == IDLE) begin
      start = 1'b1;
    end else if (!hold) begin
      tick_n = shift_en ? '0 : tick_cnt + 1'b1;
      if (shift_en) begin
        col_n = col_cnt + 1'b1;
        if (state == PIPE && col_cnt == CW'(PIPE_W - 1)) begin
          state_n  = SPACE;
          col_n    = '0;
          column_n = '0;
        end else if (state == SPACE && col_cnt == CW'(SPACING - 1)) begin
          start = 1'b1;
          col_n = '0;
        end
      end
    end
    if (start) begin
      state_n  = PIPE;
      column_n = pipe_col;
      lfsr_n   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      count_n  = pipe_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_obstacle_gen.sv
// tb_obstacle_gen: directed checks of obstacle_gen with TICK_DIV=4, GAP_H=4, PIPE_W=2, SPACING=6
module tb_obstacle_gen;
  logic        clk = 1'b0;
  logic        reset, run, hold;
  logic [15:0] column;
  logic        shift_en;
  logic [7:0]  pipe_count;
  int          vectors = 0;
  int          miscompares = 0;
  obstacle_gen #(.TICK_DIV(4), .GAP_H(4), .PIPE_W(2), .SPACING(6)) dut (
    .clk(clk), .reset(reset), .run(run), .hold(hold),
    .column(column), .shift_en(shift_en), .pipe_count(pipe_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  function automatic logic [15:0] ref_col(input logic [7:0] v);
    int lo;
    logic [15:0] c;
    lo = v[3:0] <= 12 ? int'(v[3:0]) : int'(v[3:0]) - 13;
    c = 16'hFFFF;
    for (int r = 0; r < 16; r++)
      if (r >= lo && r < lo + 4) c[r] = 1'b0;
    return c;
  endfunction
  initial begin
    logic [15:0] ec;
    logic [7:0]  m;
    logic        saw_wrap;
    int          ep;
    reset = 1'b1; run = 1'b0; hold = 1'b0;
    step(); step();
    check("rst_column", column, 16'h0000);
    check("rst_shift_en", 16'(shift_en), 16'h0000);
    check("rst_pipe_count", 16'(pipe_count), 16'h0000);
    reset = 1'b0;
    step();
    run = 1'b1;
    #1;
    check("c0_column", column, 16'h0000);
    check("c0_shift_en", 16'(shift_en), 16'h0000);
    for (int c = 1; c <= 84; c++) begin
      step();
      hold = (c >= 36 && c <= 45);
      run  = (c < 84);
      #1;
      ec = c <= 8 ? 16'hFE1F : c <= 32 ? 16'h0000 : c <= 50 ? 16'hC3FF :
           c <= 74 ? 16'h0000 : c <= 82 ? 16'hFE1F : 16'h0000;
      ep = c <= 32 ? 1 : c <= 74 ? 2 : 3;
      check($sformatf("column_c%0d", c), column, ec);
      check($sformatf("pipe_count_c%0d", c), 16'(pipe_count), 16'(ep));
      check($sformatf("shift_en_c%0d", c), 16'(shift_en),
            16'(c < 36 ? (c % 4 == 0) : c <= 45 ? 0 : ((c - 46) % 4 == 0)));
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_column", column, 16'h0000);
      check("idle_shift_en", 16'(shift_en), 16'h0000);
      check("idle_pipe_count", 16'(pipe_count), 16'd3);
    end
    run = 1'b1;
    step();
    check("restart_column", column, 16'hC3FF);
    check("restart_pipe_count", 16'(pipe_count), 16'd4);
    step(); step(); step();
    check("restart_strobe", 16'(shift_en), 16'h0001);
    m = 8'h54;
    saw_wrap = 1'b0;
    for (int k = 5; k <= 256; k++) begin
      run = 1'b0;
      step();
      check("toggle_idle", column, 16'h0000);
      run = 1'b1;
      step();
      check($sformatf("start_col_%0d", k), column, ref_col(m));
      check($sformatf("start_count_%0d", k), 16'(pipe_count), 16'(k % 256));
      if (m == 8'h0E) begin
        check("gap_wrap", column, 16'hFFE1);
        saw_wrap = 1'b1;
      end
      m = adv(m);
    end
    check("gap_wrap_seen", 16'(saw_wrap), 16'h0001);
    check("count_wrapped", 16'(pipe_count), 16'h0000);
    step();
    reset = 1'b1;
    step();
    check("midpipe_rst_column", column, 16'h0000);
    check("midpipe_rst_shift_en", 16'(shift_en), 16'h0000);
    check("midpipe_rst_count", 16'(pipe_count), 16'h0000);
    reset = 1'b0;
    step();
    check("post_rst_column", column, 16'hFE1F);
    check("post_rst_count", 16'(pipe_count), 16'h0001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
